// File: rtl/minitb_ahb_slave_if.sv
// AHB-lite bus bundle between a miniTB master and the minitb_ahb_slave responder.
// hresp is present only when MINITB_AHB_SLAVE_ERR_EN is defined.
interface minitb_ahb_slave_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic                 hsel;
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [dataWidth-1:0] hwdata;
  logic                 hready;
  logic [dataWidth-1:0] hrdata;
`ifdef MINITB_AHB_SLAVE_ERR_EN
  logic [1:0]           hresp;

  modport master (
    output hsel, htrans, haddr, hwrite, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  hsel, htrans, haddr, hwrite, hwdata,
    output hready, hrdata, hresp
  );
`else
  modport master (
    output hsel, htrans, haddr, hwrite, hwdata,
    input  hready, hrdata
  );

  modport slave (
    input  hsel, htrans, haddr, hwrite, hwdata,
    output hready, hrdata
  );
`endif
endinterface

// File: rtl/minitb_ahb_slave.sv
// Word-addressed AHB-lite memory responder (IDLE/NONSEQ subset, fixed wait states).
// Optional ERROR response for out-of-range addresses under MINITB_AHB_SLAVE_ERR_EN.
module minitb_ahb_slave #(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int memDepth   = 2 ** addrWidth,
  parameter int waitStates = 0
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset,
  minitb_ahb_slave_if.slave      bus
);

  localparam int         IDX_W     = (memDepth > 1) ? $clog2(memDepth) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(waitStates);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2,
    ST_LAST = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [IDX_W-1:0]     r_addr;
  logic                 r_write;
  logic                 r_err;
  logic                 r_hready;
  logic [dataWidth-1:0] r_mem [memDepth];

  logic                 w_accept;
  logic                 w_oor;
  logic                 w_commit;
  logic                 w_rd_active;

  assign w_accept = bus.hsel && bus.htrans[1] && r_hready;

`ifdef MINITB_AHB_SLAVE_ERR_EN
  logic [1:0] r_hresp;

  // Full-width range check: out-of-range transfers are answered with ERROR instead of wrapping.
  assign w_oor     = ({1'b0, bus.haddr} >= (addrWidth + 1)'(memDepth));
  assign bus.hresp = r_hresp;
`else
  assign w_oor     = 1'b0;
`endif

  // Transfer FSM: address-phase accept, wait-state countdown, optional two-cycle ERROR.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_hready <= 1'b1;
`ifdef MINITB_AHB_SLAVE_ERR_EN
      r_hresp  <= 2'b00;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_LAST: begin
          if (w_accept) begin
            r_addr  <= bus.haddr[IDX_W-1:0];
            r_write <= bus.hwrite;
            r_err   <= w_oor;
            if (WAIT_INIT != 4'd0) begin
              r_state  <= ST_WAIT;
              r_cnt    <= WAIT_INIT;
              r_hready <= 1'b0;
`ifdef MINITB_AHB_SLAVE_ERR_EN
              r_hresp  <= 2'b00;
`endif
            end else if (w_oor) begin
              r_state  <= ST_ERR;
              r_cnt    <= 4'd0;
              r_hready <= 1'b0;
`ifdef MINITB_AHB_SLAVE_ERR_EN
              r_hresp  <= 2'b01;
`endif
            end else begin
              r_state  <= ST_LAST;
              r_cnt    <= 4'd0;
              r_hready <= 1'b1;
`ifdef MINITB_AHB_SLAVE_ERR_EN
              r_hresp  <= 2'b00;
`endif
            end
          end else begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_err    <= 1'b0;
            r_hready <= 1'b1;
`ifdef MINITB_AHB_SLAVE_ERR_EN
            r_hresp  <= 2'b00;
`endif
          end
        end
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt <= 4'd0;
            if (r_err) begin
              r_state  <= ST_ERR;
              r_hready <= 1'b0;
`ifdef MINITB_AHB_SLAVE_ERR_EN
              r_hresp  <= 2'b01;
`endif
            end else begin
              r_state  <= ST_LAST;
              r_hready <= 1'b1;
`ifdef MINITB_AHB_SLAVE_ERR_EN
              r_hresp  <= 2'b00;
`endif
            end
          end else begin
            r_state  <= ST_WAIT;
            r_cnt    <= r_cnt - 4'd1;
            r_hready <= 1'b0;
`ifdef MINITB_AHB_SLAVE_ERR_EN
            r_hresp  <= 2'b00;
`endif
          end
        end
        ST_ERR: begin
          // Second ERROR cycle: hready rises while hresp stays ERROR.
          r_state  <= ST_LAST;
          r_cnt    <= 4'd0;
          r_hready <= 1'b1;
`ifdef MINITB_AHB_SLAVE_ERR_EN
          r_hresp  <= 2'b01;
`endif
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= 4'd0;
          r_err    <= 1'b0;
          r_hready <= 1'b1;
`ifdef MINITB_AHB_SLAVE_ERR_EN
          r_hresp  <= 2'b00;
`endif
        end
      endcase
    end
  end

  assign w_commit    = (r_state == ST_LAST) && r_write && !r_err;
  assign w_rd_active = (r_state != ST_IDLE) && !r_write && !r_err;

  // Write port: commits only at the end of the final data-phase cycle; hwdata is ignored otherwise.
  always_ff @(posedge i_hclk) begin
    if (!i_hreset && w_commit) begin
      r_mem[r_addr] <= bus.hwdata;
    end
  end

  assign bus.hready = r_hready;
  assign bus.hrdata = w_rd_active ? r_mem[r_addr] : '0;

endmodule
